regs_xfer_ctrl: RTL

Sequencer and arbiter in front of the 16×32-bit register file in the AES datapath. It shares the file between two requesters, requester 0 (host/bus side) and requester 1 (AES core, e.g. key expansion and state load/store). Each request moves one 128-bit block as four consecutive 32-bit words, read or write. The block owns the file's `select`, `LD_REG` and `D_in` and captures `D_out`.

---
 rtl/regs_xfer_ctrl_pkg.sv | 24 ++
 rtl/regs_xfer_ctrl_rr_arb2.sv | 46 ++++
 rtl/regs_xfer_ctrl.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/regs_xfer_ctrl_pkg.sv
// Shared types and constants for the AES register-file transfer sequencer.
// Latency: n/a (types, constants and one pure helper function).
// Backpressure: n/a.
package regs_xfer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } xfer_state_t;

  localparam int N_WORDS = 16;   // register file depth
  localparam int BEATS   = 4;    // 32-bit words per AES block
  localparam int WORD_W  = 32;
  localparam int BLK_W   = BEATS * WORD_W;

  typedef logic [BLK_W-1:0] blk_t;

  // Word k of a block; word 0 is the most significant word.
  function automatic logic [WORD_W-1:0] blk_word(input blk_t b, input int k);
    return b[(BEATS-1-k)*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/regs_xfer_ctrl_rr_arb2.sv
// Two-way round-robin arbiter: combinational pick, registered last-grant pointer.
// Latency: pick is combinational; pointer updates on the edge that accepts a grant.
// Backpressure: grant_en_i low freezes the pointer; requests are simply not taken.
//
// Ports:
//   clk_i, rst_ni  : clock and asynchronous active-low reset
//   req_i[1:0]     : request levels
//   grant_en_i     : the caller takes the current pick this cycle
//   any_o          : at least one request pending
//   winner_o       : index of the picked requester (valid when any_o)
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       grant_en_i,
  output logic       any_o,
  output logic       winner_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    winner_o = 1'b0;
    case (req_i)
      2'b01:   winner_o = 1'b0;
      2'b10:   winner_o = 1'b1;
      // Tie: the requester that was not served last goes first.
      2'b11:   winner_o = ~last_q;
      default: winner_o = 1'b0;
    endcase
  end

  assign any_o  = |req_i;
  assign last_d = (grant_en_i && any_o) ? winner_o : last_q;

  // Pointer resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/regs_xfer_ctrl.sv
// Arbitrates two requesters onto the 16x32 AES register file and sequences 4-word block moves.
// Latency: gnt 1 cycle after req is sampled, 4 beat cycles, done in the 5th, IDLE in the 6th.
// Backpressure: req is a level held until gnt; only sampled in IDLE, ignored while busy.
//
// Ports:
//   Clk, Reset_n         : clock, asynchronous active-low reset
//   req, we              : per-requester request level and write(1)/read(0)
//   base0/1, wdata0/1    : per-requester first word address and write block
//   gnt, done            : one-cycle accept and completion pulses, one bit per requester
//   rdata                : last completed read block (word 0 in the top 32 bits)
//   busy                 : block is not IDLE
//   LD_REG, select, D_in : register file write enable, address, write data
//   D_out                : register file combinational read data
module regs_xfer_ctrl
  import regs_xfer_pkg::*;
#(
  parameter int N_WORDS = regs_xfer_pkg::N_WORDS,
  parameter int BEATS   = regs_xfer_pkg::BEATS
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic [1:0]   req,
  input  logic [1:0]   we,
  input  logic [3:0]   base0,
  input  logic [3:0]   base1,
  input  logic [127:0] wdata0,
  input  logic [127:0] wdata1,
  output logic [1:0]   gnt,
  output logic [1:0]   done,
  output logic [127:0] rdata,
  output logic         busy,
  output logic         LD_REG,
  output logic [4:0]   select,
  output logic [31:0]  D_in,
  input  logic [31:0]  D_out
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  // Word address of beat k, wrapping inside the file; bit 4 is always 0.
  function automatic logic [4:0] word_addr(input logic [3:0] b, input logic [BEAT_W-1:0] k);
    logic [4:0] s;
    s = {1'b0, b} + 5'(k);
    if (s >= 5'(N_WORDS)) begin
      s = s - 5'(N_WORDS);
    end
    return {1'b0, s[3:0]};
  endfunction

  xfer_state_t       state_q;
  logic [BEAT_W-1:0] beat_q;
  logic              owner_q;
  logic              we_q;
  logic [3:0]        base_q;
  blk_t              wdata_q;
  blk_t              rbuf_q;
  blk_t              rbuf_d;
  blk_t              rdata_q;
  logic [1:0]        gnt_q;
  logic [1:0]        done_q;
  logic [4:0]        select_q;
  logic              ld_q;
  logic [31:0]       din_q;

  // Arbiter pick and the winner's request fields, consumed only in IDLE.
  logic       arb_any;
  logic       arb_win;
  logic       win_we;
  logic [3:0] win_base;
  blk_t       win_data;

  rr_arb2 u_arb (
    .clk_i      (Clk),
    .rst_ni     (Reset_n),
    .req_i      (req),
    .grant_en_i (state_q == IDLE),
    .any_o      (arb_any),
    .winner_o   (arb_win)
  );

  assign win_we   = we[arb_win];
  assign win_base = arb_win ? base1  : base0;
  assign win_data = arb_win ? wdata1 : wdata0;

  // Read words collect in a shadow buffer so rdata only changes when the
  // whole block is in; the final word is merged straight from D_out.
  always_comb begin
    rbuf_d = rbuf_q;
    rbuf_d[(BEATS-1-int'(beat_q))*WORD_W +: WORD_W] = D_out;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      beat_q   <= '0;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      base_q   <= '0;
      wdata_q  <= '0;
      rbuf_q   <= '0;
      rdata_q  <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      select_q <= '0;
      ld_q     <= 1'b0;
      din_q    <= '0;
    end else begin
      gnt_q  <= '0;
      done_q <= '0;
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            state_q  <= XFER;
            beat_q   <= '0;
            owner_q  <= arb_win;
            we_q     <= win_we;
            base_q   <= win_base;
            wdata_q  <= win_data;
            gnt_q    <= arb_win ? 2'b10 : 2'b01;
            // Beat 0 drive values are registered here so the file port
            // never sees a combinational path from req.
            select_q <= word_addr(win_base, '0);
            ld_q     <= win_we;
            din_q    <= blk_word(win_data, 0);
          end
        end
        XFER: begin
          if (!we_q) begin
            rbuf_q <= rbuf_d;
          end
          if (beat_q == LAST_BEAT) begin
            state_q  <= DONE;
            done_q   <= owner_q ? 2'b10 : 2'b01;
            if (!we_q) begin
              rdata_q <= rbuf_d;
            end
            select_q <= '0;
            ld_q     <= 1'b0;
            din_q    <= '0;
          end else begin
            beat_q   <= beat_q + BEAT_W'(1);
            select_q <= word_addr(base_q, beat_q + BEAT_W'(1));
            din_q    <= blk_word(wdata_q, int'(beat_q) + 1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          beat_q  <= '0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign rdata  = rdata_q;
  assign busy   = (state_q != IDLE);
  assign LD_REG = ld_q;
  assign select = select_q;
  assign D_in   = din_q;

endmodule
